stats_display: RTL and testbench
================================

# stats_display

Readout end of the CPU performance counters. Selects one of the four 32-bit statistics counters (total cycles, unconditional jumps, conditional branches, taken conditional branches), converts it to decimal with a sequential double-dabble engine, and time-multiplexes the low 8 decimal digits onto an 8-digit common-anode 7-segment display. Sits at board top level between the statistics counters and the display pins.

## Interface
- SCAN_DIV, 100000, clk cycles each digit is lit; must be ≥ 2.
- REFRESH, 1000000, clk cycles between periodic re-conversions; must be ≥ 40.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Synchronous, active-high.
- circle_count  in  32  total cycle count.
- no_j_count  in  32  unconditional jump count.
- j_count  in  32  conditional branch count.
- j_ok_count  in  32  taken conditional branch count.
- halt  in  1  CPU halted (level).
- sel  in  2  counter select: 0 circle_count, 1 no_j_count, 2 j_count, 3 j_ok_count.
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- an  out  8  digit enables, active-low; bit i is decimal digit i (0 is least significant).
- busy  out  1  conversion in progress (state ≠ IDLE).

## Operation
- Conversion FSM with states IDLE, SHIFT and COMMIT.
- Request sources:
  - sel differs from its 1-cycle-delayed copy sel_q;
  - halt rising edge, detected with a registered copy;
  - refresh timer reaching REFRESH-1 (timer wraps to 0 and free-runs);
  - reset (sets pending=1).
- Any request sets the pending flag. Pending is cleared only when a capture occurs. Multiple requests collapse into one.
- IDLE with pending=1:
  - capture the counter selected by the current sel into bin[31:0];
  - bcd[39:0]=0, cnt=0;
  - go to SHIFT.
- SHIFT, each cycle:
  - add 3 to every BCD nibble ≥5;
  - shift {bcd,bin} left 1;
  - cnt++.
  - After the 32nd shift (cnt==31 that cycle), go to COMMIT.
- COMMIT:
  - digits[31:0] ← bcd[31:0];
  - ovf ← |bcd[39:32];
  - go to IDLE.
- Scan: divider counts 0..SCAN_DIV-1. On wrap, idx (3 bits) increments mod 8.
- Displayed digit at idx:
  - Leading-zero blanking: digit idx>0 is blank when it and all higher digits in digits[31:0] are 0. Digit 0 is never blanked.
  - Blank digit: segments a–g off.
  - dp lit when ovf=1, or when idx==0 and halt=1.
- Hex to segment map (active-low, dp=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - Clear bit 7 to light dp.
- seg and an are registered from idx and digits. Glitch-free: both update on the same edge.

## Timing
- Reset values:
  - seg=8'hFF, an=8'hFF, busy=0;
  - digits=0, ovf=0, idx=0, divider=0, refresh timer=0;
  - state=IDLE, pending=1.
- Request latency: a sel change is seen on edge E (sel_q mismatch). Pending is set at E+1. If IDLE, capture happens at E+2.
- Capture edge T: busy=1 from T+1. SHIFT occupies edges T+1..T+32. COMMIT is at T+33. New digits and busy=0 from T+34.
- Requests during SHIFT/COMMIT are held in pending. The next capture occurs on the edge immediately after COMMIT completes (state IDLE for exactly 1 cycle).
- The captured value is frozen. Input counter changes during conversion do not affect the result.
- seg/an reflect the new digits no later than the edge after digits update.
- rst mid-conversion: the next edge forces all reset values, and the conversion is discarded. The first capture is on the first edge with rst=0.

## Test plan
- Reset release, sel=0, circle_count=32'd12345678:
  - busy rises 1 cycle after capture and falls 34 cycles after capture;
  - scanning idx 0..7 gives seg 80,F8,82,92,99,B0,A4,F9;
  - an cycles FE,FD,...,7F.
- sel=1, no_j_count=7, halt=0: digit 0 seg=F8; digits 1–7 seg=FF.
- sel=3, j_ok_count=32'hFFFFFFFF (4294967295): ovf=1; digits show 94967295, every seg has bit7=0 (e.g. digit 0 = 8'h12).
- Change sel 0→2 at cycle 10 of a conversion (j_count=100): the current conversion completes; the next capture comes on the edge right after COMMIT; the display ends at 100 (seg C0,C0,F9 then FF).
- halt 0→1 with circle_count=0: conversion triggered; digit 0 seg=8'h40; other digits FF.
- Assert rst during SHIFT cycle 15: the next edge gives busy=0, seg=an=FF, digits=0. After release, a fresh conversion starts and completes after 34 cycles.

Source files
------------

// File: rtl/stats_display.sv
// Readout of the CPU statistics counters: picks one counter, converts it to
// decimal with a sequential double-dabble engine and scans 8 digits onto a 7-seg display.
module stats_display #(
    parameter int SCAN_DIV = 100000,
    parameter int REFRESH  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] circle_count,
    input  logic [31:0] no_j_count,
    input  logic [31:0] j_count,
    input  logic [31:0] j_ok_count,
    input  logic        halt,
    input  logic [1:0]  sel,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic        busy
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int REF_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Adds 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [39:0] dabble_adjust(input logic [39:0] b);
        logic [39:0] r;
        r = b;
        for (int i = 0; i < 10; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [7:0] seg_lut(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        bin_q, bin_d;
    logic [39:0]        bcd_q, bcd_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        digits_q, digits_d;
    logic               ovf_q, ovf_d;
    logic               pending_q, pending_d;
    logic               req_q, req_d;
    logic [1:0]         sel_q, sel_d;
    logic               halt_q, halt_d;
    logic [REF_W-1:0]   refresh_q, refresh_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         an_q, an_d;
    logic               busy_q, busy_d;

    logic               capture_s;
    logic [31:0]        sel_val_s;
    logic [71:0]        shift_s;
    logic [7:0]         upper_nz_s;
    logic [3:0]         digit_s;

    // Request detection: sel change, halt rising edge, refresh wrap; pending collapses them.
    always_comb begin
        sel_d     = sel;
        halt_d    = halt;
        refresh_d = refresh_q + REF_W'(1);
        req_d     = 1'b0;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            req_d     = 1'b1;
        end else begin
            refresh_d = refresh_q + REF_W'(1);
        end
        if ((sel != sel_q) || (halt && !halt_q)) begin
            req_d = 1'b1;
        end else begin
            req_d = req_d;
        end
        pending_d = req_q | (pending_q & ~capture_s);
    end

    // Counter select for the capture.
    always_comb begin
        sel_val_s = 32'd0;
        case (sel)
            2'd0:    sel_val_s = circle_count;
            2'd1:    sel_val_s = no_j_count;
            2'd2:    sel_val_s = j_count;
            2'd3:    sel_val_s = j_ok_count;
            default: sel_val_s = 32'd0;
        endcase
    end

    // Conversion FSM: capture, 32 shift-and-adjust steps, then commit to the display.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        ovf_d     = ovf_q;
        capture_s = 1'b0;
        shift_s   = {dabble_adjust(bcd_q), bin_q} << 1;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    capture_s = 1'b1;
                    bin_d     = sel_val_s;
                    bcd_d     = 40'd0;
                    cnt_d     = 5'd0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bcd_d = shift_s[71:32];
                bin_d = shift_s[31:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                digits_d = bcd_q[31:0];
                ovf_d    = |bcd_q[39:32];
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Digit scan and segment/anode generation with leading-zero blanking.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            idx_d = idx_q;
        end
        for (int i = 0; i < 8; i++) begin
            upper_nz_s[i] = |(digits_q >> (4 * i));
        end
        digit_s = digits_q[{idx_q, 2'b00} +: 4];
        if ((idx_q != 3'd0) && !upper_nz_s[idx_q]) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = seg_lut(digit_s);
        end
        if (ovf_q || ((idx_q == 3'd0) && halt)) begin
            seg_d = seg_d & 8'h7F;
        end else begin
            seg_d = seg_d;
        end
        an_d = ~(8'b0000_0001 << idx_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bin_q     <= 32'd0;
            bcd_q     <= 40'd0;
            cnt_q     <= 5'd0;
            digits_q  <= 32'd0;
            ovf_q     <= 1'b0;
            pending_q <= 1'b1;
            req_q     <= 1'b0;
            sel_q     <= sel;
            halt_q    <= halt;
            refresh_q <= '0;
            div_q     <= '0;
            idx_q     <= 3'd0;
            seg_q     <= 8'hFF;
            an_q      <= 8'hFF;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            sel_q     <= sel_d;
            halt_q    <= halt_d;
            refresh_q <= refresh_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            busy_q    <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_stats_display.sv
// Self-checking bench for stats_display: directed phases with random counter
// values, checked against a decimal-arithmetic model of the display.
module tb_stats_display;

    localparam int SCAN = 4;
    localparam int REFR = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] circle_count = 32'd0;
    logic [31:0] no_j_count = 32'd0;
    logic [31:0] j_count = 32'd0;
    logic [31:0] j_ok_count = 32'd0;
    logic        halt = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        busy;

    int total = 0;
    int bad = 0;

    stats_display #(.SCAN_DIV(SCAN), .REFRESH(REFR)) dut (
        .clk(clk), .rst(rst),
        .circle_count(circle_count), .no_j_count(no_j_count),
        .j_count(j_count), .j_ok_count(j_ok_count),
        .halt(halt), .sel(sel),
        .seg(seg), .an(an), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected segment byte for display digit i of value v, from decimal arithmetic.
    function automatic logic [7:0] model_seg(input logic [31:0] v, input logic h, input int i);
        logic [7:0] lut [0:9];
        longint unsigned val, low, p, upper;
        logic [7:0] s;
        lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        val = 64'(v);
        low = val % 64'd100000000;
        p = 64'd1;
        for (int k = 0; k < i; k++) p = p * 64'd10;
        upper = low / p;
        s = (i > 0 && upper == 64'd0) ? 8'hFF : lut[int'(upper % 64'd10)];
        if (val >= 64'd100000000 || (i == 0 && h)) s[7] = 1'b0;
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset seg", 32'(seg), 32'hFF);
        chk("reset an", 32'(an), 32'hFF);
        chk("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
    endtask

    // Busy must be high for 33 sampled cycles after the capture edge, low on the 34th.
    task automatic busy_profile(input string tag, input int c0);
        for (int c = c0; c <= 34; c++) begin
            @(negedge clk);
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy), (c <= 33) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic scan_check(input string tag, input logic [31:0] v, input logic h);
        logic [7:0] seen;
        int idx;
        seen = 8'h00;
        for (int n = 0; n < 8 * SCAN + 4; n++) begin
            @(negedge clk);
            idx = -1;
            for (int k = 0; k < 8; k++) if (an == ~(8'b1 << k)) idx = k;
            if (idx >= 0) begin
                chk($sformatf("%s seg d%0d", tag, idx), 32'(seg), 32'(model_seg(v, h, idx)));
                seen[idx] = 1'b1;
            end
        end
        chk({tag, " an coverage"}, 32'(seen), 32'hFF);
    endtask

    initial begin
        logic [31:0] rv;

        // Phase 1: 12345678 on circle_count; input changes during conversion are ignored.
        sel = 2'd0; circle_count = 32'd12345678;
        no_j_count = 32'd7; j_count = 32'd100; j_ok_count = 32'hFFFF_FFFF;
        do_reset();
        @(negedge clk);
        chk("p1 busy c1", 32'(busy), 32'd1);
        circle_count = $urandom;
        busy_profile("p1", 2);
        scan_check("p1", 32'd12345678, 1'b0);

        // Phase 2: small value with blanking.
        sel = 2'd1;
        do_reset();
        busy_profile("p2", 1);
        scan_check("p2", 32'd7, 1'b0);

        // Phase 3: overflow above 8 digits.
        sel = 2'd3;
        do_reset();
        busy_profile("p3", 1);
        scan_check("p3", 32'hFFFF_FFFF, 1'b0);

        // Phase 4: random values on each counter.
        for (int r = 0; r < 3; r++) begin
            rv = (r == 0) ? ($urandom % 32'd100000000) : $urandom;
            sel = 2'(r + 1);
            no_j_count = rv; j_count = rv; j_ok_count = rv;
            do_reset();
            busy_profile($sformatf("p4r%0d", r), 1);
            scan_check($sformatf("p4r%0d", r), rv, 1'b0);
        end

        // Phase 5: sel change mid-conversion is held and served right after commit.
        sel = 2'd0; circle_count = 32'd12345678; j_count = 32'd100;
        do_reset();
        repeat (10) @(negedge clk);
        sel = 2'd2;
        for (int c = 11; c <= 35; c++) begin
            @(negedge clk);
            if (c == 33) chk("p5 busy c33", 32'(busy), 32'd1);
            if (c == 34) chk("p5 busy c34", 32'(busy), 32'd0);
            if (c == 35) chk("p5 busy c35", 32'(busy), 32'd1);
        end
        wait_idle("p5");
        scan_check("p5", 32'd100, 1'b0);

        // Phase 6: halt rising edge triggers a conversion and lights dp on digit 0.
        sel = 2'd0; circle_count = 32'd0; halt = 1'b0;
        do_reset();
        busy_profile("p6", 1);
        scan_check("p6a", 32'd0, 1'b0);
        halt = 1'b1;
        repeat (2) @(negedge clk);
        chk("p6 halt busy early", 32'(busy), 32'd0);
        @(negedge clk);
        chk("p6 halt busy", 32'(busy), 32'd1);
        wait_idle("p6");
        scan_check("p6b", 32'd0, 1'b1);
        halt = 1'b0;

        // Phase 7: reset during SHIFT discards the conversion.
        sel = 2'd2; j_count = 32'd100;
        do_reset();
        repeat (15) @(negedge clk);
        chk("p7 busy before rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("p7 rst busy", 32'(busy), 32'd0);
        chk("p7 rst seg", 32'(seg), 32'hFF);
        chk("p7 rst an", 32'(an), 32'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy_profile("p7", 1);
        scan_check("p7", 32'd100, 1'b0);

        // Phase 8: refresh timer alone triggers a re-conversion.
        sel = 2'd1; no_j_count = 32'd4321;
        do_reset();
        for (int c = 1; c <= REFR + 2; c++) begin
            @(negedge clk);
            if (c == 34) chk("p8 busy after first", 32'(busy), 32'd0);
            if (c == REFR + 1) chk("p8 refresh busy early", 32'(busy), 32'd0);
            if (c == REFR + 2) chk("p8 refresh busy", 32'(busy), 32'd1);
        end
        wait_idle("p8");
        scan_check("p8", 32'd4321, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
